// File: rtl/dsp_mem_loader_if.sv
// Host stream channel into dsp_mem_loader: framed words with valid/ready/last.
// The host bridge drives the master side and the loader sits on the slave side.
interface dsp_mem_loader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_last;
  logic                  s_ready;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/dsp_mem_loader.sv
// Decodes framed host packets {unit/addr, count, data...} into registered writes
// on the shared dsp_unit memory-load bus, with a one-hot per-unit write strobe.
module dsp_mem_loader #(
  parameter int N_UNITS        = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 13
) (
  input  logic                      clk,
  input  logic                      reset,
  dsp_mem_loader_if.slave           s,
  output logic [MEM_ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0]     mem_write_data,
  output logic [N_UNITS-1:0]        mem_write_en,
  output logic                      busy,
  output logic                      pkt_done,
  output logic                      err,
  input  logic                      err_clr,
  output logic [1:0]                err_code
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_UNIT    = 2'd1;
  localparam logic [1:0] ERR_EARLY   = 2'd2;
  localparam logic [1:0] ERR_MISSING = 2'd3;

  localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_ZERO = {MEM_ADDR_WIDTH{1'b0}};
  localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_ONE  = {{(MEM_ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [N_UNITS-1:0]        EN_NONE   = {N_UNITS{1'b0}};

  function automatic logic [N_UNITS-1:0] unit_onehot(input logic [7:0] unit);
    logic [N_UNITS-1:0] oh;
    oh = EN_NONE;
    for (int i = 0; i < N_UNITS; i++) begin
      if (32'(unit) == 32'(i)) begin
        oh[i] = 1'b1;
      end else begin
        oh[i] = 1'b0;
      end
    end
    return oh;
  endfunction

  state_t                    state_r, state_nxt_s;
  logic [7:0]                unit_r, unit_nxt_s;
  logic [MEM_ADDR_WIDTH-1:0] addr_r, addr_nxt_s;
  logic [MEM_ADDR_WIDTH-1:0] rem_r, rem_nxt_s;
  logic                      unit_flag_r, unit_flag_nxt_s;
  logic [N_UNITS-1:0]        wr_en_r, wr_en_nxt_s;
  logic [MEM_ADDR_WIDTH-1:0] wr_addr_r, wr_addr_nxt_s;
  logic [DATA_WIDTH-1:0]     wr_data_r, wr_data_nxt_s;
  logic                      busy_r, busy_nxt_s;
  logic                      done_r, done_nxt_s;
  logic                      ready_r, ready_nxt_s;
  logic                      err_r, err_nxt_s;
  logic [1:0]                err_code_r, err_code_nxt_s;
  logic                      err_set_s;
  logic [1:0]                err_val_s;

  logic                      ready_s;
  logic                      accept_s;
  logic [7:0]                hdr_unit_s;
  logic [MEM_ADDR_WIDTH-1:0] hdr_field_s;
  logic                      field_zero_s;
  logic                      rem_one_s;
  logic                      unit_ok_s;

  // ready_r idles high; gating with reset keeps s_ready low only while reset is held
  assign ready_s      = ready_r & ~reset;
  assign s.s_ready    = ready_s;
  assign accept_s     = s.s_valid & ready_s;
  assign hdr_unit_s   = s.s_data[DATA_WIDTH-1 -: 8];
  assign hdr_field_s  = s.s_data[MEM_ADDR_WIDTH-1:0];
  assign field_zero_s = (hdr_field_s == ADDR_ZERO);
  assign rem_one_s    = (rem_r == ADDR_ONE);
  assign unit_ok_s    = (32'(unit_r) < 32'(N_UNITS));

  assign mem_write_addr = wr_addr_r;
  assign mem_write_data = wr_data_r;
  assign mem_write_en   = wr_en_r;
  assign busy           = busy_r;
  assign pkt_done       = done_r;
  assign err            = err_r;
  assign err_code       = err_code_r;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode from the accepted word and its framing
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = s.s_last ? ST_DONE : ST_LEN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LEN: begin
        if (accept_s) begin
          if (field_zero_s) begin
            state_nxt_s = s.s_last ? ST_DONE : ST_DRAIN;
          end else begin
            state_nxt_s = s.s_last ? ST_DONE : ST_DATA;
          end
        end else begin
          state_nxt_s = ST_LEN;
        end
      end
      ST_DATA: begin
        if (accept_s) begin
          if (rem_one_s) begin
            state_nxt_s = s.s_last ? ST_DONE : ST_DRAIN;
          end else begin
            state_nxt_s = s.s_last ? ST_DONE : ST_DATA;
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_DRAIN: begin
        if (accept_s && s.s_last) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Datapath, write-bus and status next values
  always_comb begin
    unit_nxt_s      = unit_r;
    addr_nxt_s      = addr_r;
    rem_nxt_s       = rem_r;
    unit_flag_nxt_s = unit_flag_r;
    wr_en_nxt_s     = EN_NONE;
    wr_addr_nxt_s   = wr_addr_r;
    wr_data_nxt_s   = wr_data_r;
    err_set_s       = 1'b0;
    err_val_s       = ERR_NONE;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          unit_nxt_s      = hdr_unit_s;
          addr_nxt_s      = hdr_field_s;
          unit_flag_nxt_s = 1'b0;
          err_set_s       = s.s_last;
          err_val_s       = s.s_last ? ERR_EARLY : ERR_NONE;
        end else begin
          unit_nxt_s = unit_r;
        end
      end
      ST_LEN: begin
        if (accept_s) begin
          rem_nxt_s = hdr_field_s;
          if (field_zero_s && !s.s_last) begin
            err_set_s = 1'b1;
            err_val_s = ERR_MISSING;
          end else if (!field_zero_s && s.s_last) begin
            err_set_s = 1'b1;
            err_val_s = ERR_EARLY;
          end else begin
            err_set_s = 1'b0;
          end
        end else begin
          rem_nxt_s = rem_r;
        end
      end
      ST_DATA: begin
        if (accept_s) begin
          // address field wraps naturally at its width
          addr_nxt_s = addr_r + ADDR_ONE;
          rem_nxt_s  = rem_r - ADDR_ONE;
          if (unit_ok_s) begin
            wr_en_nxt_s   = unit_onehot(unit_r);
            wr_addr_nxt_s = addr_r;
            wr_data_nxt_s = s.s_data;
          end else begin
            wr_en_nxt_s     = EN_NONE;
            unit_flag_nxt_s = 1'b1;
          end
          if (rem_one_s && !s.s_last) begin
            err_set_s = 1'b1;
            err_val_s = ERR_MISSING;
          end else if (!rem_one_s && s.s_last) begin
            err_set_s = 1'b1;
            err_val_s = ERR_EARLY;
          end else if (!unit_ok_s && !unit_flag_r) begin
            err_set_s = 1'b1;
            err_val_s = ERR_UNIT;
          end else begin
            err_set_s = 1'b0;
          end
        end else begin
          wr_en_nxt_s = EN_NONE;
        end
      end
      ST_DRAIN: begin
        wr_en_nxt_s = EN_NONE;
      end
      ST_DONE: begin
        wr_en_nxt_s = EN_NONE;
      end
      default: begin
        wr_en_nxt_s = EN_NONE;
      end
    endcase

    busy_nxt_s  = (state_nxt_s != ST_IDLE);
    done_nxt_s  = (state_nxt_s == ST_DONE);
    ready_nxt_s = (state_nxt_s != ST_DONE);

    // a new error outranks a simultaneous clear
    if (err_set_s) begin
      err_nxt_s      = 1'b1;
      err_code_nxt_s = err_val_s;
    end else if (err_clr) begin
      err_nxt_s      = 1'b0;
      err_code_nxt_s = ERR_NONE;
    end else begin
      err_nxt_s      = err_r;
      err_code_nxt_s = err_code_r;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      unit_r      <= 8'd0;
      addr_r      <= ADDR_ZERO;
      rem_r       <= ADDR_ZERO;
      unit_flag_r <= 1'b0;
      wr_en_r     <= EN_NONE;
      wr_addr_r   <= ADDR_ZERO;
      wr_data_r   <= {DATA_WIDTH{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      ready_r     <= 1'b1;
      err_r       <= 1'b0;
      err_code_r  <= ERR_NONE;
    end else begin
      unit_r      <= unit_nxt_s;
      addr_r      <= addr_nxt_s;
      rem_r       <= rem_nxt_s;
      unit_flag_r <= unit_flag_nxt_s;
      wr_en_r     <= wr_en_nxt_s;
      wr_addr_r   <= wr_addr_nxt_s;
      wr_data_r   <= wr_data_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      ready_r     <= ready_nxt_s;
      err_r       <= err_nxt_s;
      err_code_r  <= err_code_nxt_s;
    end
  end

endmodule

// File: tb/tb_dsp_mem_loader.sv
// Scoreboard bench for dsp_mem_loader: the driver queues expected writes and
// packet results, a negedge monitor pops and compares them as the DUT emits.
module tb_dsp_mem_loader;
  localparam int N_UNITS = 8;
  localparam int DW      = 32;
  localparam int AW      = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          err_clr;
  logic [AW-1:0] mem_write_addr;
  logic [DW-1:0] mem_write_data;
  logic [N_UNITS-1:0] mem_write_en;
  logic          busy;
  logic          pkt_done;
  logic          err;
  logic [1:0]    err_code;

  dsp_mem_loader_if #(.DATA_WIDTH(DW)) sif ();

  dsp_mem_loader #(
    .N_UNITS(N_UNITS),
    .DATA_WIDTH(DW),
    .MEM_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s(sif),
    .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en),
    .busy(busy),
    .pkt_done(pkt_done),
    .err(err),
    .err_clr(err_clr),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_UNITS-1:0] en;
    logic [AW-1:0]      addr;
    logic [DW-1:0]      data;
  } wr_t;

  wr_t        exp_wr[$];
  logic [1:0] exp_pkt[$];
  int         n_cmp  = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every strobe must match the head of the write queue
  always @(negedge clk) begin
    wr_t cur;
    wr_t e;
    logic [1:0] ec;
    cur = '{en: mem_write_en, addr: mem_write_addr, data: mem_write_data};
    if (mem_write_en !== {N_UNITS{1'b0}}) begin
      if (exp_wr.size() == 0) begin
        check("unexpected_write", 64'(cur), 64'd0);
      end else begin
        e = exp_wr.pop_front();
        check("write", 64'(cur), 64'(e));
      end
    end
    if (pkt_done === 1'b1) begin
      if (exp_pkt.size() == 0) begin
        check("unexpected_pkt_done", 64'd1, 64'd0);
      end else begin
        ec = exp_pkt.pop_front();
        check("pkt_err_code", 64'(err_code), 64'(ec));
        check("pkt_err", 64'(err), 64'(ec != 2'd0));
        check("ready_low_in_done", 64'(sif.s_ready), 64'd0);
        check("busy_in_done", 64'(busy), 64'd1);
      end
    end
  end

  task automatic put(input logic [DW-1:0] d, input logic l);
    int guard;
    guard = 0;
    @(negedge clk);
    sif.s_valid = 1'b1;
    sif.s_data  = d;
    sif.s_last  = l;
    while (sif.s_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_accept", 64'(sif.s_ready), 64'd1);
    @(posedge clk);
  endtask

  task automatic bubble();
    @(negedge clk);
    sif.s_valid = 1'b0;
  endtask

  // One packet: header, optional count word, ndata words, s_last on the final word sent
  task automatic pkt(input logic [7:0] unit, input logic [AW-1:0] addr, input logic [AW-1:0] cnt,
                     input bit has_w1, input int ndata, input logic [N_UNITS-1:0] exp_en,
                     input int exp_writes, input logic [1:0] exp_code, input logic [DW-1:0] base,
                     input bit gap);
    for (int i = 0; i < exp_writes; i++) begin
      exp_wr.push_back('{en: exp_en, addr: AW'(addr + AW'(i)), data: base + DW'(i)});
    end
    exp_pkt.push_back(exp_code);
    put({unit, 11'd0, addr}, !has_w1);
    if (has_w1) begin
      put({19'd0, cnt}, ndata == 0);
      for (int i = 0; i < ndata; i++) begin
        if (gap && i == 1) bubble();
        put(base + DW'(i), i == ndata - 1);
      end
    end
    bubble();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_cleared", 64'({err, err_code}), 64'd0);
  endtask

  initial begin
    reset       = 1'b1;
    err_clr     = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_data  = 32'h0000_0000;
    sif.s_last  = 1'b0;
    @(negedge clk);
    check("reset_outputs", 64'({mem_write_en, mem_write_addr, mem_write_data}), 64'd0);
    check("reset_status", 64'({busy, pkt_done, err, err_code}), 64'd0);
    check("reset_ready", 64'(sif.s_ready), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_after_release", 64'(sif.s_ready), 64'd1);

    //  unit   addr      cnt    w1  nd  en     wr code base          gap
    pkt(8'd2, 13'h0000, 13'd4, 1, 4, 8'h04, 4, 2'd0, 32'h0000_00A0, 0);
    pkt(8'd0, 13'h1FFE, 13'd3, 1, 3, 8'h01, 3, 2'd0, 32'h0000_00B0, 1);
    pkt(8'd9, 13'h0010, 13'd2, 1, 2, 8'h00, 0, 2'd1, 32'h0000_00C0, 0);
    pkt(8'd3, 13'h0100, 13'd5, 1, 3, 8'h08, 3, 2'd2, 32'h0000_00D0, 0);
    pkt(8'd1, 13'h0200, 13'd2, 1, 4, 8'h02, 2, 2'd3, 32'h0000_00E0, 0);
    pkt(8'd4, 13'h0005, 13'd0, 1, 0, 8'h10, 0, 2'd0, 32'h0000_0000, 0);
    pkt(8'd5, 13'h0030, 13'd0, 0, 0, 8'h20, 0, 2'd2, 32'h0000_0000, 0);
    pkt(8'd6, 13'h0040, 13'd0, 1, 2, 8'h40, 0, 2'd3, 32'h0000_00F0, 0);
    pkt(8'd7, 13'h1000, 13'd1, 1, 1, 8'h80, 1, 2'd0, 32'h1234_5678, 0);

    // Reset in the middle of a 6-word packet after two words
    exp_wr.push_back('{en: 8'h04, addr: 13'h0040, data: 32'h0000_0D00});
    exp_wr.push_back('{en: 8'h04, addr: 13'h0041, data: 32'h0000_0D01});
    put({8'd2, 11'd0, 13'h0040}, 1'b0);
    put({19'd0, 13'd6}, 1'b0);
    put(32'h0000_0D00, 1'b0);
    put(32'h0000_0D01, 1'b0);
    @(negedge clk);
    sif.s_data = 32'h0000_0D02;
    #1;
    reset = 1'b1;
    #1;
    check("abort_outputs", 64'({mem_write_en, mem_write_addr, mem_write_data}), 64'd0);
    check("abort_status", 64'({busy, pkt_done, err, err_code}), 64'd0);
    check("abort_ready", 64'(sif.s_ready), 64'd0);
    repeat (3) @(negedge clk);
    reset       = 1'b0;
    sif.s_valid = 1'b0;
    #1;
    check("ready_after_abort", 64'(sif.s_ready), 64'd1);
    pkt(8'd1, 13'h0000, 13'd0, 1, 0, 8'h02, 0, 2'd0, 32'h0000_0000, 0);

    repeat (4) @(negedge clk);
    check("write_queue_drained", 64'(exp_wr.size()), 64'd0);
    check("pkt_queue_drained", 64'(exp_pkt.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule
